// File: rtl/des_key_sched_if.sv
// Bus between the top level / DES core and the DES key schedule: key load
// strobe with key and mode, round-index read port, and schedule status.
interface des_key_sched_if;
  logic [63:0] key_in;
  logic        mode_in;
  logic        key_en;
  logic [3:0]  rd_idx;
  logic [47:0] subkey_out;
  logic        key_ready;
  logic        busy;
  logic        parity_err;

  modport master (
    output key_in, mode_in, key_en, rd_idx,
    input  subkey_out, key_ready, busy, parity_err
  );

  modport slave (
    input  key_in, mode_in, key_en, rd_idx,
    output subkey_out, key_ready, busy, parity_err
  );
endinterface

// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 on load, one PC-2 subkey per clk2x cycle into a 16x48
// register file, mode-aware registered read port. Optional KEY_PARITY_CHK_EN.
module des_key_sched #(
  parameter int NUM_ROUNDS = 16,
  parameter int SUBKEY_W   = 48
) (
  input  logic           clk2x,
  input  logic           srst,
  des_key_sched_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_e;

  // Permutation tables in DES numbering (bit 1 = MSB of the source word).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [55:0] cd);
    logic [SUBKEY_W-1:0] r;
    for (int i = 0; i < SUBKEY_W; i++) r[SUBKEY_W-1-i] = cd[56-PC2[i]];
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [27:0]         c_q, c_d, d_q, d_d, c_rot, d_rot;
  logic                mode_q, mode_d;
  logic [SUBKEY_W-1:0] subkey_out_q, subkey_out_d;
  logic [SUBKEY_W-1:0] rf_q [NUM_ROUNDS];
  logic                rf_we;
  logic [SUBKEY_W-1:0] rf_wdata;
  logic [IDX_W-1:0]    eff_idx;
  logic                shift1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    d_d      = d_q;
    mode_d   = mode_q;
    rf_we    = 1'b0;

    shift1   = (cnt_q == 4'd0) || (cnt_q == 4'd1) || (cnt_q == 4'd8) || (cnt_q == 4'd15);
    c_rot    = shift1 ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
    d_rot    = shift1 ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
    rf_wdata = pc2({c_rot, d_rot});

    if (bus.key_en) begin
      // A load always wins, so a restart never mixes subkeys of two keys.
      {c_d, d_d} = pc1(bus.key_in);
      mode_d     = bus.mode_in;
      cnt_d      = '0;
      state_d    = GEN;
    end else if (state_q == GEN) begin
      c_d   = c_rot;
      d_d   = d_rot;
      rf_we = 1'b1;
      if (cnt_q == IDX_W'(NUM_ROUNDS - 1)) state_d = DONE;
      else                                 cnt_d   = cnt_q + 1'b1;
    end
  end

  always_comb begin
    eff_idx      = mode_q ? (4'd15 - bus.rd_idx) : bus.rd_idx;
    subkey_out_d = (state_q == DONE) ? rf_q[eff_idx] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk2x) begin
    if (!srst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      subkey_out_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      subkey_out_q <= subkey_out_d;
    end
  end

  // NOTE: the register file and C/D/mode are not reset; key_ready gates every use of them.
  always_ff @(posedge clk2x) begin
    c_q    <= c_d;
    d_q    <= d_d;
    mode_q <= mode_d;
    if (rf_we) rf_q[cnt_q] <= rf_wdata;
  end

  assign bus.subkey_out = subkey_out_q;
  assign bus.key_ready  = (state_q == DONE);
  assign bus.busy       = (state_q == GEN);

`ifdef KEY_PARITY_CHK_EN
  logic parity_err_q, parity_err_d;

  // DES wants odd parity in every byte; any even byte flags the key (advisory only).
  always_comb begin
    parity_err_d = parity_err_q;
    if (bus.key_en) begin
      parity_err_d = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if (!(^bus.key_in[8*b +: 8])) parity_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk2x) begin
    if (!srst) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- DES key schedule for the bhargava scrambler/descrambler DES path; clocked on clk2x.
- Captures the 64-bit key and the mode on a key_en pulse, then generates the 16 48-bit round subkeys at one per cycle into an internal 16x48 register file.
- Serves subkeys to the DES round engine through a registered, mode-aware read port.
- Sits directly upstream of the DES core and consumes key_in/mode_in/key_en from the top level.

Parameters:
- NUM_ROUNDS, 16, number of subkeys generated and stored; fixed by DES, index width 4.
- SUBKEY_W, 48, width of each PC-2 subkey.

Ports:
- clk2x  in  1  clock.
- srst  in  1  synchronous, active-low reset.
- key_in  in  64  DES key, parity bits at positions 8,16,...,64 (DES numbering, bit 1 = MSB).
- mode_in  in  1  1 = decrypt, 0 = encrypt; sampled with key_en.
- key_en  in  1  single-cycle load strobe.
- rd_idx  in  4  round index requested by the DES core.
- subkey_out  out  48  subkey for rd_idx, registered.
- key_ready  out  1  high when all 16 subkeys are valid.
- busy  out  1  high during generation.
- parity_err  out  1  key parity error flag (see Optional Feature).

Behaviour:
- Reset is decided as: srst synchronous, active-low, clock clk2x. While srst = 0:
  - state = IDLE;
  - subkey_out = 0, key_ready = 0, busy = 0, parity_err = 0;
  - round counter = 0;
  - register-file contents are don't-care, because key_ready gates their use.
- States: IDLE, GEN, DONE.
- key_en = 1 at edge N, any state:
  - C/D registers <= PC-1(key_in), 28 bits each;
  - mode latched;
  - cnt <= 0;
  - key_ready <= 0, busy <= 1;
  - state <= GEN.
- GEN, each edge:
  - rotate C and D left by SHIFT[cnt], where SHIFT = 1 for cnt in {0,1,8,15} and 2 otherwise;
  - write PC-2(rotated C,D) to slot cnt, and store the rotated C/D;
  - cnt <= cnt + 1.
  - On the edge that writes slot 15: state <= DONE, busy <= 0, key_ready <= 1.
- Latency: key_en sampled at edge N; slots 0..15 written at edges N+1..N+16; key_ready = 1 after edge N+16 (16 cycles of busy).
- DONE: holds until the next key_en. After 16 rounds C/D return to their PC-1 value; this is not relied on.
- key_en during GEN: aborts and restarts from the new key, key_ready stays 0. No partial-schedule mixing.
- key_en in DONE: key_ready drops on the same edge; the old subkeys are invalid from then on.
- srst low mid-GEN: immediate return to IDLE; a fresh key_en is required.
- Read port, 1-cycle latency:
  - subkey_out <= key_ready ? K[eff_idx] : 0;
  - eff_idx = latched_mode ? 15 - rd_idx : rd_idx, unsigned 4-bit, so rd_idx 0 in decrypt returns K16;
  - key_ready is evaluated at the same edge (registered value). The edge that drops key_ready still returns the old key's data; the following edge returns 0.
- rd_idx is any value 0..15; there are no out-of-range values.
- mode_in is ignored except when key_en = 1.
- Permutation tables PC-1/PC-2 are pure wiring. No arithmetic beyond the 4-bit counter, which never wraps because GEN exits at 15.

Optional Feature:
- Macro KEY_PARITY_CHK_EN.
- Defined:
  - at the key_en edge, parity_err <= 1 if any byte of key_in has even parity (DES requires odd parity per byte), else 0;
  - held until the next key_en or reset;
  - schedule generation proceeds regardless (the flag is advisory only).
- Undefined: parity_err tied to 0, and no parity logic is synthesised.

Test Plan:
- Textbook vector: key_en with key_in = 64'h133457799BBCDFF1, mode_in = 0 -> busy high 16 cycles, key_ready after 16 edges; rd_idx = 0 -> subkey_out = 48'h1B02EFFC7072; rd_idx = 15 -> 48'hCB3D8B0E17F5.
- Decrypt mode: same key, mode_in = 1 -> rd_idx = 0 gives 48'hCB3D8B0E17F5, rd_idx = 15 gives 48'h1B02EFFC7072.
- Restart: key_en at edge N, second key_en (key 64'hA1B2C3D4E5F61234) at N+5 -> key_ready stays 0 until edge N+21; all subkeys match a reference model for the second key only.
- Reset mid-GEN: srst = 0 at N+8 for one cycle -> key_ready = 0, busy = 0, subkey_out = 0; key_ready never rises without a new key_en.
- Read gating: rd_idx = 3 while busy -> subkey_out = 0; after a key_en in DONE, the first read returns the old K4 and the next returns 0.
- KEY_PARITY_CHK_EN defined:
  - key 64'hA1B2C3D4E5F61234 (byte B2 has even parity) -> parity_err = 1 one edge after key_en;
  - key 64'h0101010101010101 -> parity_err = 0;
  - undefined -> parity_err always 0.
